// File: rtl/lift_pkg.sv
// Shared types and default sizes for the lift scheduler and its helpers.
package lift_pkg;

    localparam int N_FLOORS = 8;
    localparam int FLOOR_W  = $clog2(N_FLOORS);

    typedef logic [FLOOR_W-1:0] floor_t;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE,
        DECIDE,
        STEP,
        DOOR
    } sched_state_e;

endpackage

// File: rtl/lift_scheduler_if.sv
// Single-floor step handshake between the scheduler (master) and the lift (slave).
interface lift_scheduler_if;
    import lift_pkg::*;

    logic step_req;   // move one floor; held until step_ack
    logic step_up;    // direction of the requested move, stable while step_req=1
    logic step_ack;   // one-cycle pulse: step finished, floor already updated

    modport master (
        output step_req,
        output step_up,
        input  step_ack
    );

    modport slave (
        input  step_req,
        input  step_up,
        output step_ack
    );

endinterface

// File: rtl/lift_door_timer.sv
// Door dwell down-counter: load sets DOOR_CYCLES-1, dec counts towards zero,
// zero flags the final open cycle.
module lift_door_timer #(
    parameter int DOOR_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);
    import lift_pkg::*;

    localparam int CNT_W = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;

    logic [CNT_W-1:0] r_count;

    // Load has priority over decrement; the counter parks at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= CNT_W'(DOOR_CYCLES - 1);
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/lift_scheduler.sv
// Single-car lift scheduler: latches button presses, picks direction with
// SCAN, issues one-floor steps and holds the door open at served floors.
// Optional feature macro: LIFT_SCHED_DOOR_REOPEN_EN (a press for the current
// floor while the door is open extends the dwell instead of being latched).
module lift_scheduler #(
    parameter int N_FLOORS    = lift_pkg::N_FLOORS,
    parameter int FLOOR_W     = $clog2(N_FLOORS),
    parameter int DOOR_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] btn_req,
    input  logic [FLOOR_W-1:0]  cur_floor,
    lift_scheduler_if.master    step_if,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending,
    output logic                dir_up,
    output logic                idle
);
    import lift_pkg::*;

    // Any request strictly above the given floor.
    function automatic logic any_above(input logic [N_FLOORS-1:0] req,
                                       input logic [FLOOR_W-1:0]  floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i > int'(floor)) hit = hit | req[i];
        end
        return hit;
    endfunction

    // Any request strictly below the given floor.
    function automatic logic any_below(input logic [N_FLOORS-1:0] req,
                                       input logic [FLOOR_W-1:0]  floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i < int'(floor)) hit = hit | req[i];
        end
        return hit;
    endfunction

    sched_state_e        r_state;
    logic [N_FLOORS-1:0] r_pending;
    logic                r_dir_up;
    logic                r_step_req;
    logic                r_step_up;
    logic                r_door_open;
    logic                r_idle;

    logic [N_FLOORS-1:0] w_floor_onehot;
    logic [N_FLOORS-1:0] w_btn_eff;
    logic [N_FLOORS-1:0] w_clear_mask;
    logic [N_FLOORS-1:0] w_pending_next;
    logic                w_here;
    logic                w_above;
    logic                w_below;
    logic                w_reopen;
    logic                w_door_entry;
    logic                w_timer_load;
    logic                w_timer_dec;
    logic                w_timer_zero;

    // One-hot decode of the current floor, used for both clearing and reopen.
    for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_floor_dec
        assign w_floor_onehot[gi] = (cur_floor == FLOOR_W'(gi));
    end

    assign w_here  = |(r_pending & w_floor_onehot);
    assign w_above = any_above(r_pending, cur_floor);
    assign w_below = any_below(r_pending, cur_floor);

`ifdef LIFT_SCHED_DOOR_REOPEN_EN
    // A press for the floor whose door is open restarts the dwell.
    assign w_reopen = (r_state == DOOR) && (|(btn_req & w_floor_onehot));
`else
    assign w_reopen = 1'b0;
`endif

    // A reopening press is consumed by the timer, never latched.
    assign w_btn_eff      = w_reopen ? (btn_req & ~w_floor_onehot) : btn_req;
    // The served bit is dropped in the same cycle the door is commanded open,
    // which also swallows a press for this floor arriving in that cycle.
    assign w_door_entry   = (r_state == DECIDE) && w_here;
    assign w_clear_mask   = w_door_entry ? w_floor_onehot : '0;
    assign w_pending_next = (r_pending | w_btn_eff) & ~w_clear_mask;

    assign w_timer_load = w_door_entry || w_reopen;
    assign w_timer_dec  = (r_state == DOOR) && !w_reopen;

    lift_door_timer #(
        .DOOR_CYCLES (DOOR_CYCLES)
    ) u_door_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_timer_load),
        .dec   (w_timer_dec),
        .zero  (w_timer_zero)
    );

    // Scheduler FSM with request latching and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_dir_up    <= 1'b1;
            r_step_req  <= 1'b0;
            r_step_up   <= 1'b1;
            r_door_open <= 1'b0;
            r_idle      <= 1'b1;
        end else begin
            r_pending <= w_pending_next;
            unique case (r_state)
                IDLE: begin
                    // Leave on the press edge itself to keep press->step at 2 cycles.
                    if (w_pending_next != '0) begin
                        r_state <= DECIDE;
                        r_idle  <= 1'b0;
                    end else begin
                        r_idle  <= 1'b1;
                    end
                end
                DECIDE: begin
                    if (w_here) begin
                        r_state     <= DOOR;
                        r_door_open <= 1'b1;
                    end else if (r_dir_up && w_above) begin
                        r_state    <= STEP;
                        r_step_req <= 1'b1;
                        r_step_up  <= 1'b1;
                    end else if (!r_dir_up && w_below) begin
                        r_state    <= STEP;
                        r_step_req <= 1'b1;
                        r_step_up  <= 1'b0;
                    end else if (w_above) begin
                        r_dir_up   <= 1'b1;
                        r_state    <= STEP;
                        r_step_req <= 1'b1;
                        r_step_up  <= 1'b1;
                    end else if (w_below) begin
                        r_dir_up   <= 1'b0;
                        r_state    <= STEP;
                        r_step_req <= 1'b1;
                        r_step_up  <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        r_idle  <= (w_pending_next == '0);
                    end
                end
                STEP: begin
                    if (step_if.step_ack) begin
                        r_step_req <= 1'b0;
                        r_state    <= DECIDE;
                    end
                end
                DOOR: begin
                    if (!w_reopen && w_timer_zero) begin
                        r_door_open <= 1'b0;
                        r_state     <= DECIDE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign step_if.step_req = r_step_req;
    assign step_if.step_up  = r_step_up;
    assign door_open        = r_door_open;
    assign pending          = r_pending;
    assign dir_up           = r_dir_up;
    assign idle             = r_idle;

endmodule
